done_tracker: RTL and testbench
===============================

Name: done_tracker

Overview:
- Completion-side partner of the asynchronous clock generator: collects per-unit completion from the datapath units of one round and drives the `done` handshake whose falling edge triggers the next generated clock.
- Contains its own watchdog, so a stuck unit forces `done` low instead of relying only on the generator's timeout path.
- Synchronous to `clk`. Any assertion of `planBreset` aborts the block back to idle.

Parameters:
- N_UNITS, 4, number of participating completion sources.
- TIMEOUT, 16, cycles in COLLECT before a forced release; legal range 2..2^TMR_W-1.
- TMR_W, 5, width of the watchdog timer.
- CNT_W, 8, width of the round and timeout counters.

Ports:
- clk  input  1  sampling clock; all state changes on the rising edge.
- planBreset  input  1  reset, asynchronous, active-high; clears all state.
- start  input  1  single-cycle pulse that opens a round; honoured only in IDLE.
- unit_mask  input  N_UNITS  units participating in the round; sampled only on an accepted start.
- unit_done  input  N_UNITS  per-unit completion level or pulse; sticky-captured during COLLECT.
- done  output  1  high while a round is open; its 1->0 edge signals round completion to the generator.
- busy  output  1  high in COLLECT and RELEASE.
- pending  output  N_UNITS  masked units not yet complete; frozen after a timeout until the next start.
- timeout_flag  output  1  sticky; set on a watchdog release, cleared by an accepted start or by reset.
- round_cnt  output  CNT_W  rounds completed normally; wraps modulo 2^CNT_W.
- timeout_cnt  output  CNT_W  watchdog releases; saturates at all-ones.

Behaviour:
- Reset values: state IDLE, done=0, busy=0, pending=0, timeout_flag=0, round_cnt=0, timeout_cnt=0, timer=0.
- Reset mid-round takes effect immediately (asynchronous); no completion is counted for the aborted round.

States (all outputs registered):
- IDLE, done=0.
  - start=1 with unit_mask!=0: pending<=unit_mask, timer<=0, timeout_flag<=0, done<=1, go to COLLECT.
  - start=1 with unit_mask==0: done<=1 for exactly one cycle, then RELEASE with round_cnt+1 (empty round).
- COLLECT, done=1.
  - Each cycle: nxt = pending & ~unit_done; pending<=nxt; timer<=timer+1.
  - nxt==0: done<=0, round_cnt<=round_cnt+1, go to RELEASE.
  - Else if timer==TIMEOUT-1: done<=0, timeout_flag<=1, timeout_cnt<=sat(timeout_cnt+1), pending<=nxt (frozen), go to RELEASE.
  - Completion and timeout in the same cycle: completion wins, so no timeout is recorded.
- RELEASE, done=0: held for exactly one cycle (minimum low time toward the generator), then IDLE.

Latency:
- Accepted start at edge k gives done=1 after edge k+1.
- Last pending bit seen in unit_done at edge m gives done=0 after edge m.
- Shortest round: start, then all units complete on the next edge, so done is high for 1 cycle.

Input and handshake rules:
- unit_done bits outside the latched mask are ignored.
- unit_done already high on the start cycle is not captured; capture begins in COLLECT.
- start in COLLECT or RELEASE is ignored. It is neither queued nor counted.
- done never toggles more than once per round. Between consecutive falling edges there are at least 2 cycles of done=0 (RELEASE plus IDLE).
- Counter widths are exact: round_cnt wraps from 2^CNT_W-1 to 0; timeout_cnt holds at 2^CNT_W-1.

Test Plan:
- Reset, then start with mask=4'b1011; pulse unit_done bits 0, 1, 3 on separate cycles -> pending steps 1011->1010->1000->0000; done falls on the bit-3 edge; round_cnt=1; timeout_flag=0.
- Mask=4'b0001, unit_done never asserted, TIMEOUT=16 -> done falls exactly 16 cycles after entering COLLECT; timeout_flag=1; timeout_cnt=1; pending frozen at 0001; round_cnt unchanged.
- Last unit_done arrives on the cycle where timer==15 -> normal completion: round_cnt+1, timeout_flag=0, timeout_cnt unchanged.
- start with mask=0 -> done high for 1 cycle, then low; round_cnt+1; busy high for the RELEASE cycle only.
- start re-pulsed during COLLECT and during RELEASE -> ignored, pending unchanged. unit_done bit 2 asserted with mask=0001 -> no effect on pending.
- Assert planBreset mid-COLLECT with round_cnt=5 -> all outputs zero immediately without waiting for a clk edge. Force 256 timeouts with CNT_W=8 -> timeout_cnt saturates at 255. Complete 256 rounds -> round_cnt wraps to 0.

Source files
------------

// File: rtl/done_tracker.sv
// ---------------------------------------------------------------------------
// done_tracker
//
// Purpose:
//   Completion-side partner of the asynchronous clock generator. It opens a
//   round on `start`, collects sticky per-unit completion from the datapath
//   units, and drives the `done` handshake. The 1->0 edge of `done` tells the
//   generator the round is over. A built-in watchdog forces `done` low if a
//   participating unit never completes.
//
// Ports:
//   clk          in   sampling clock, rising edge
//   planBreset   in   asynchronous active-high reset, clears all state
//   start        in   single-cycle pulse opening a round (honoured in IDLE only)
//   unit_mask    in   [N_UNITS] participating units, sampled on accepted start
//   unit_done    in   [N_UNITS] per-unit completion, sticky-captured in COLLECT
//   done         out  high while a round is open
//   busy         out  high in COLLECT and RELEASE
//   pending      out  [N_UNITS] masked units not yet complete
//   timeout_flag out  sticky watchdog-release indicator
//   round_cnt    out  [CNT_W] normally completed rounds, wraps
//   timeout_cnt  out  [CNT_W] watchdog releases, saturates
// ---------------------------------------------------------------------------
module done_tracker #(
    parameter int N_UNITS = 4,
    parameter int TIMEOUT = 16,
    parameter int TMR_W   = 5,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               planBreset,
    input  logic               start,
    input  logic [N_UNITS-1:0] unit_mask,
    input  logic [N_UNITS-1:0] unit_done,
    output logic               done,
    output logic               busy,
    output logic [N_UNITS-1:0] pending,
    output logic               timeout_flag,
    output logic [CNT_W-1:0]   round_cnt,
    output logic [CNT_W-1:0]   timeout_cnt
);

    // S_EMPTY is the single done-high cycle of a round with no participants;
    // busy stays low there so that busy covers only the RELEASE cycle.
    typedef enum logic [1:0] {
        S_IDLE,
        S_EMPTY,
        S_COLLECT,
        S_RELEASE
    } state_t;

    localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT - 1);

    state_t             state_q,        state_d;
    logic               done_q,         done_d;
    logic               busy_q,         busy_d;
    logic [N_UNITS-1:0] pending_q,      pending_d;
    logic               timeout_flag_q, timeout_flag_d;
    logic [CNT_W-1:0]   round_cnt_q,    round_cnt_d;
    logic [CNT_W-1:0]   timeout_cnt_q,  timeout_cnt_d;
    logic [TMR_W-1:0]   timer_q,        timer_d;
    logic [N_UNITS-1:0] pending_nxt;

    always_comb begin
        state_d        = state_q;
        done_d         = done_q;
        busy_d         = busy_q;
        pending_d      = pending_q;
        timeout_flag_d = timeout_flag_q;
        round_cnt_d    = round_cnt_q;
        timeout_cnt_d  = timeout_cnt_q;
        timer_d        = timer_q;

        // Sticky capture: a pending bit only ever clears. Bits outside the
        // latched mask are already zero in pending_q, so they are ignored.
        pending_nxt = pending_q & ~unit_done;

        case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    pending_d      = unit_mask;
                    timer_d        = '0;
                    timeout_flag_d = 1'b0;
                    done_d         = 1'b1;
                    if (unit_mask != '0) begin
                        busy_d  = 1'b1;
                        state_d = S_COLLECT;
                    end else begin
                        state_d = S_EMPTY;
                    end
                end
            end

            S_EMPTY: begin
                done_d      = 1'b0;
                busy_d      = 1'b1;
                round_cnt_d = round_cnt_q + 1'b1;
                state_d     = S_RELEASE;
            end

            S_COLLECT: begin
                pending_d = pending_nxt;
                timer_d   = timer_q + 1'b1;
                // Completion is tested first so a unit finishing on the very
                // last watchdog cycle still counts as a normal round.
                if (pending_nxt == '0) begin
                    done_d      = 1'b0;
                    round_cnt_d = round_cnt_q + 1'b1;
                    state_d     = S_RELEASE;
                end else if (timer_q == TIMER_LAST) begin
                    done_d         = 1'b0;
                    timeout_flag_d = 1'b1;
                    if (timeout_cnt_q != '1) begin
                        timeout_cnt_d = timeout_cnt_q + 1'b1;
                    end
                    state_d = S_RELEASE;
                end
            end

            S_RELEASE: begin
                // One guaranteed low cycle toward the generator; a start seen
                // here is dropped, not queued.
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge planBreset) begin
        if (planBreset) begin
            state_q        <= S_IDLE;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
            pending_q      <= '0;
            timeout_flag_q <= 1'b0;
            round_cnt_q    <= '0;
            timeout_cnt_q  <= '0;
            timer_q        <= '0;
        end else begin
            state_q        <= state_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
            pending_q      <= pending_d;
            timeout_flag_q <= timeout_flag_d;
            round_cnt_q    <= round_cnt_d;
            timeout_cnt_q  <= timeout_cnt_d;
            timer_q        <= timer_d;
        end
    end

    assign done         = done_q;
    assign busy         = busy_q;
    assign pending      = pending_q;
    assign timeout_flag = timeout_flag_q;
    assign round_cnt    = round_cnt_q;
    assign timeout_cnt  = timeout_cnt_q;

endmodule

// File: tb/tb_done_tracker.sv
// ---------------------------------------------------------------------------
// tb_done_tracker
//
// Directed bench for done_tracker. The stimulus process pushes the expected
// end-of-round state into a queue before driving each round; the monitor
// process pops one entry on every falling edge of done and compares it,
// including how many cycles done was high. A few point checks (reset values,
// pending stepping, asynchronous reset) are made directly from stimulus.
// ---------------------------------------------------------------------------
module tb_done_tracker;

    logic       clk;
    logic       planBreset;
    logic       start;
    logic [3:0] unit_mask;
    logic [3:0] unit_done;
    logic       done;
    logic       busy;
    logic [3:0] pending;
    logic       timeout_flag;
    logic [7:0] round_cnt;
    logic [7:0] timeout_cnt;

    typedef struct {
        logic [3:0] pending;
        logic       tflag;
        logic [7:0] rcnt;
        logic [7:0] tcnt;
        int         high;
    } exp_t;

    exp_t exp_q[$];

    int   tests;
    int   fails;
    logic prev_done;
    int   high_cycles;

    done_tracker #(
        .N_UNITS(4),
        .TIMEOUT(16),
        .TMR_W  (5),
        .CNT_W  (8)
    ) dut (
        .clk         (clk),
        .planBreset  (planBreset),
        .start       (start),
        .unit_mask   (unit_mask),
        .unit_done   (unit_done),
        .done        (done),
        .busy        (busy),
        .pending     (pending),
        .timeout_flag(timeout_flag),
        .round_cnt   (round_cnt),
        .timeout_cnt (timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one set of inputs for exactly one rising edge, return 1 time
    // unit after that edge so outputs can be checked right away.
    task automatic applyStimulus(input logic s, input logic [3:0] m,
                                 input logic [3:0] d);
        start     = s;
        unit_mask = m;
        unit_done = d;
        @(posedge clk);
        #1;
        start     = 1'b0;
        unit_mask = 4'b0000;
        unit_done = 4'b0000;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'b0000, 4'b0000);
    endtask

    task automatic pushExpect(input logic [3:0] p, input logic tf,
                              input logic [7:0] rc, input logic [7:0] tc,
                              input int hi);
        exp_t e;
        e.pending = p;
        e.tflag   = tf;
        e.rcnt    = rc;
        e.tcnt    = tc;
        e.high    = hi;
        exp_q.push_back(e);
    endtask

    // Monitor: one scoreboard entry per falling edge of done.
    initial begin
        exp_t e;
        prev_done   = 1'b0;
        high_cycles = 0;
        forever begin
            @(negedge clk);
            if (planBreset) begin
                prev_done   = 1'b0;
                high_cycles = 0;
            end else begin
                if (done) begin
                    high_cycles++;
                end else if (prev_done) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected_done_fall: got fall, expected none");
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("fall_pending", 32'(pending), 32'(e.pending));
                        checkOutput("fall_timeout_flag", 32'(timeout_flag), 32'(e.tflag));
                        checkOutput("fall_round_cnt", 32'(round_cnt), 32'(e.rcnt));
                        checkOutput("fall_timeout_cnt", 32'(timeout_cnt), 32'(e.tcnt));
                        checkOutput("fall_busy", 32'(busy), 32'd1);
                        checkOutput("fall_high_cycles", high_cycles, e.high);
                    end
                    high_cycles = 0;
                end
                prev_done = done;
            end
        end
    end

    initial begin
        tests      = 0;
        fails      = 0;
        planBreset = 1'b1;
        start      = 1'b0;
        unit_mask  = 4'b0000;
        unit_done  = 4'b0000;
        #1;
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_pending", 32'(pending), 32'd0);
        checkOutput("reset_timeout_flag", 32'(timeout_flag), 32'd0);
        checkOutput("reset_round_cnt", 32'(round_cnt), 32'd0);
        checkOutput("reset_timeout_cnt", 32'(timeout_cnt), 32'd0);
        @(posedge clk);
        #1;
        planBreset = 1'b0;
        idleCycles(2);

        // Normal round, mask 1011, units finish one at a time.
        pushExpect(4'b0000, 1'b0, 8'd1, 8'd0, 3);
        applyStimulus(1'b1, 4'b1011, 4'b0000);
        checkOutput("r1_done_up", 32'(done), 32'd1);
        checkOutput("r1_busy", 32'(busy), 32'd1);
        checkOutput("r1_pending0", 32'(pending), 32'hb);
        applyStimulus(1'b0, 4'b0000, 4'b0001);
        checkOutput("r1_pending1", 32'(pending), 32'ha);
        applyStimulus(1'b0, 4'b0000, 4'b0010);
        checkOutput("r1_pending2", 32'(pending), 32'h8);
        applyStimulus(1'b0, 4'b0000, 4'b1000);
        checkOutput("r1_done_down", 32'(done), 32'd0);
        idleCycles(1);

        // Watchdog: mask 0001, only an unmasked unit reports, start re-pulsed.
        pushExpect(4'b0001, 1'b1, 8'd1, 8'd1, 16);
        applyStimulus(1'b1, 4'b0001, 4'b0000);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(i == 4, 4'b1111, 4'b0100);
        end
        checkOutput("to_still_high", 32'(done), 32'd1);
        checkOutput("to_pending_masked", 32'(pending), 32'h1);
        applyStimulus(1'b0, 4'b0000, 4'b0000);
        checkOutput("to_done_down", 32'(done), 32'd0);
        applyStimulus(1'b1, 4'b1111, 4'b0000);
        checkOutput("release_start_ignored", 32'(done), 32'd0);
        checkOutput("release_pending_frozen", 32'(pending), 32'h1);
        checkOutput("release_flag_kept", 32'(timeout_flag), 32'd1);

        // Last unit completes on the final watchdog cycle: completion wins.
        pushExpect(4'b0000, 1'b0, 8'd2, 8'd1, 16);
        applyStimulus(1'b1, 4'b0011, 4'b0000);
        checkOutput("start_clears_flag", 32'(timeout_flag), 32'd0);
        applyStimulus(1'b0, 4'b0000, 4'b0001);
        idleCycles(14);
        applyStimulus(1'b0, 4'b0000, 4'b0010);
        idleCycles(1);

        // Empty round.
        pushExpect(4'b0000, 1'b0, 8'd3, 8'd1, 1);
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        checkOutput("empty_done_up", 32'(done), 32'd1);
        checkOutput("empty_busy_low", 32'(busy), 32'd0);
        applyStimulus(1'b0, 4'b0000, 4'b0000);
        checkOutput("empty_busy_release", 32'(busy), 32'd1);
        applyStimulus(1'b0, 4'b0000, 4'b0000);
        checkOutput("empty_busy_idle", 32'(busy), 32'd0);

        // unit_done high on the start cycle is not captured; shortest round.
        pushExpect(4'b0000, 1'b0, 8'd4, 8'd1, 1);
        applyStimulus(1'b1, 4'b0001, 4'b0001);
        checkOutput("startcyc_not_captured", 32'(pending), 32'h1);
        applyStimulus(1'b0, 4'b0000, 4'b0001);
        idleCycles(1);
        pushExpect(4'b0000, 1'b0, 8'd5, 8'd1, 1);
        applyStimulus(1'b1, 4'b0001, 4'b0000);
        applyStimulus(1'b0, 4'b0000, 4'b0001);
        idleCycles(1);

        // Asynchronous reset mid-COLLECT.
        applyStimulus(1'b1, 4'b0001, 4'b0000);
        #2;
        planBreset = 1'b1;
        #1;
        checkOutput("areset_done", 32'(done), 32'd0);
        checkOutput("areset_busy", 32'(busy), 32'd0);
        checkOutput("areset_pending", 32'(pending), 32'd0);
        checkOutput("areset_round_cnt", 32'(round_cnt), 32'd0);
        checkOutput("areset_timeout_cnt", 32'(timeout_cnt), 32'd0);
        @(posedge clk);
        #1;
        planBreset = 1'b0;
        idleCycles(1);

        // 257 watchdog releases: timeout_cnt saturates at 255.
        for (int r = 0; r < 257; r++) begin
            pushExpect(4'b0001, 1'b1, 8'd0, (r >= 254) ? 8'd255 : 8'(r + 1), 16);
            applyStimulus(1'b1, 4'b0001, 4'b0000);
            idleCycles(17);
        end
        checkOutput("tcnt_saturated", 32'(timeout_cnt), 32'd255);

        // 256 normal rounds: round_cnt wraps back to 0.
        for (int r = 0; r < 256; r++) begin
            pushExpect(4'b0000, 1'b0, 8'((r + 1) % 256), 8'd255, 1);
            applyStimulus(1'b1, 4'b0001, 4'b0000);
            applyStimulus(1'b0, 4'b0000, 4'b0001);
            idleCycles(1);
        end
        checkOutput("rcnt_wrapped", 32'(round_cnt), 32'd0);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idleCycles(1);
        checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
